// File: rtl/counter_ctrl.sv
// Run/pause/done sequencer for the 4-digit up/down step counter.
// Turns debounced button levels into registered step/clr pulses at a divided rate.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped; cleared or reset; waits for a run edge
// RUN   | divider counting; step pulses once every TICK_DIV cycles
// PAUSE | divider frozen; a run edge resumes with the same phase
// DONE  | halted at the count limit; a dir edge turns back, a run edge goes idle
module counter_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic       btn_clr,
  input  logic       stop_en,
  input  logic [3:0] n0,
  input  logic [3:0] n1,
  input  logic [3:0] n2,
  input  logic [3:0] n3,
  output logic       step,
  output logic       dir,
  output logic       clr,
  output logic [1:0] state
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic            step_d, clr_d, dir_d;
  logic            prev_run, prev_dir, prev_clr;
  logic            rise_run, rise_dir, rise_clr;
  logic [15:0]     count;
  logic            at_limit;

  assign rise_run = btn_run & ~prev_run;
  assign rise_dir = btn_dir & ~prev_dir;
  assign rise_clr = btn_clr & ~prev_clr;

  assign count    = {n3, n2, n1, n0};
  // The counter value seen here already reflects the previous step.
  assign at_limit = stop_en & (dir ? (count == 16'h0000) : (count == 16'hFFFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      step     <= 1'b0;
      clr      <= 1'b0;
      dir      <= 1'b0;
      prev_run <= 1'b0;
      prev_dir <= 1'b0;
      prev_clr <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      step     <= step_d;
      clr      <= clr_d;
      dir      <= dir_d;
      prev_run <= btn_run;
      prev_dir <= btn_dir;
      prev_clr <= btn_clr;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = 1'b0;
    clr_d   = 1'b0;
    dir_d   = dir ^ rise_dir;

    if (rise_clr) begin
      clr_d   = 1'b1;
      state_d = S_IDLE;
      div_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise_run) begin
            state_d = S_RUN;
            div_d   = '0;
          end
        end
        S_RUN: begin
          if (rise_run) begin
            state_d = S_PAUSE;
          end else if (div_q == DIV_TC) begin
            div_d = '0;
            if (at_limit) state_d = S_DONE;
            else          step_d  = 1'b1;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        S_PAUSE: begin
          if (rise_run) state_d = S_RUN;
        end
        S_DONE: begin
          // A direction change outranks a run edge so counting can leave the limit.
          if (rise_dir) begin
            state_d = S_RUN;
            div_d   = '0;
          end else if (rise_run) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state = state_q;

endmodule
